// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses AA/BB byte frames into register-file writes/reads
// and returns read data as one TX byte. Optional inter-byte timeout via `CTRL_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 4,
  parameter int                TIMEOUT_CYC = 4096,
  parameter logic [DATA_W-1:0] CMD_WR      = 8'hAA,
  parameter logic [DATA_W-1:0] CMD_RD      = 8'hBB
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_rx_valid,
  output logic [ADDR_W-1:0] o_rf_addr,
  output logic [DATA_W-1:0] o_rf_wr_data,
  output logic              o_rf_wr_en,
  output logic              o_rf_rd_en,
  input  logic [DATA_W-1:0] i_rf_rd_data,
  input  logic              i_rf_rd_valid,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_busy,
  output logic              o_overrun,
  output logic              o_frame_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] RD_ADDR = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] TX_REQ  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              tx_valid_q, tx_valid_d;
  logic              overrun_q, overrun_d;

`ifdef CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_err_q, frame_err_d;
`endif

  // Next-state and output decode for the frame parser
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    tx_data_d  = tx_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    tx_valid_d = tx_valid_q;
    overrun_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        if (i_rx_valid && i_rx_data == CMD_WR) begin
          state_d = WR_ADDR;
        end else if (i_rx_valid && i_rx_data == CMD_RD) begin
          state_d = RD_ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      WR_ADDR: begin
        if (i_rx_valid) begin
          addr_d  = i_rx_data[ADDR_W-1:0];
          state_d = WR_DATA;
        end else begin
          state_d = WR_ADDR;
        end
      end
      WR_DATA: begin
        if (i_rx_valid) begin
          wr_data_d = i_rx_data;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = WR_DATA;
        end
      end
      RD_ADDR: begin
        if (i_rx_valid) begin
          addr_d  = i_rx_data[ADDR_W-1:0];
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_WAIT: begin
        overrun_d = i_rx_valid;
        if (i_rf_rd_valid) begin
          tx_data_d  = i_rf_rd_data;
          tx_valid_d = ~i_tx_busy;
          state_d    = TX_REQ;
        end else begin
          state_d = RD_WAIT;
        end
      end
      TX_REQ: begin
        overrun_d = i_rx_valid;
        // Once requested, the first busy cycle is taken as acceptance
        if (tx_valid_q && i_tx_busy) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end else begin
          tx_valid_d = tx_valid_q | ~i_tx_busy;
          state_d    = TX_REQ;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase

`ifdef CTRL_TIMEOUT_EN
    frame_err_d = 1'b0;
    if (state_q != IDLE && !i_rx_valid && cnt_q >= CNT_W'(TIMEOUT_CYC - 1)) begin
      state_d     = IDLE;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      tx_valid_d  = 1'b0;
      frame_err_d = 1'b1;
    end else begin
      frame_err_d = 1'b0;
    end
    if (state_d == IDLE || state_d != state_q || i_rx_valid) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_data_q  <= '0;
      tx_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      tx_data_q  <= tx_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef CTRL_TIMEOUT_EN
  // Inter-byte timeout counter and frame-error pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign o_frame_err = frame_err_q;
`else
  assign o_frame_err = 1'b0;
`endif

  assign o_rf_addr    = addr_q;
  assign o_rf_wr_data = wr_data_q;
  assign o_rf_wr_en   = wr_en_q;
  assign o_rf_rd_en   = rd_en_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus random frames,
// checked against a byte-queue frame model and a model register file.
module tb_uart_cmd_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic       rf_wr_en;
  logic       rf_rd_en;
  logic [7:0] rf_rd_data;
  logic       rf_rd_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic       overrun;
  logic       frame_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] frame[$];
  logic [7:0] rf_model[16];
  bit         rd_pending;
  logic [3:0] last_rd_addr;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rf_addr(rf_addr), .o_rf_wr_data(rf_wr_data), .o_rf_wr_en(rf_wr_en),
    .o_rf_rd_en(rf_rd_en), .i_rf_rd_data(rf_rd_data), .i_rf_rd_valid(rf_rd_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_busy(tx_busy),
    .o_overrun(overrun), .o_frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_wr_en", rf_wr_en, 1'b0);
      chk("idle_rd_en", rf_rd_en, 1'b0);
      chk("idle_overrun", overrun, 1'b0);
    end
  endtask

  // Model: bytes accumulate into a frame; a frame completes by its opcode and length
  task automatic send_byte(input logic [7:0] b);
    bit exp_wr = 1'b0;
    bit exp_rd = 1'b0;
    bit exp_ovr = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] d = 8'h00;
    if (rd_pending) begin
      exp_ovr = 1'b1;
    end else begin
      frame.push_back(b);
      if (frame[0] != 8'hAA && frame[0] != 8'hBB) begin
        frame.delete();
      end else if (frame[0] == 8'hAA && frame.size() == 3) begin
        exp_wr = 1'b1; a = frame[1]; d = frame[2];
        rf_model[a[3:0]] = d;
        frame.delete();
      end else if (frame[0] == 8'hBB && frame.size() == 2) begin
        exp_rd = 1'b1; a = frame[1];
        last_rd_addr = a[3:0];
        rd_pending = 1'b1;
        frame.delete();
      end
    end
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'($urandom);
    chk("wr_en", rf_wr_en, exp_wr);
    chk("rd_en", rf_rd_en, exp_rd);
    chk("overrun", overrun, exp_ovr);
    chk("frame_err", frame_err, 1'b0);
    if (exp_wr) begin
      chk("wr_addr", rf_addr, a[3:0]);
      chk("wr_data", rf_wr_data, d);
    end
    if (exp_rd) chk("rd_addr", rf_addr, a[3:0]);
  endtask

  task automatic complete_read(input int delay, input bit inject, input bit busy_entry);
    logic [7:0] exp_d = rf_model[last_rd_addr];
    int n = 0;
    idle(delay);
    if (inject) send_byte(8'h22);
    if (busy_entry) tx_busy = 1'b1;
    rf_rd_data = exp_d; rf_rd_valid = 1'b1;
    @(posedge clk); #1;
    rf_rd_valid = 1'b0; rf_rd_data = 8'($urandom);
    if (busy_entry) begin
      idle(3);
      chk("tx_held_busy", tx_valid, 1'b0);
      tx_busy = 1'b0;
    end
    while (!tx_valid && n < 8) begin
      @(posedge clk); #1; n++;
    end
    chk("tx_valid_rise", tx_valid, 1'b1);
    chk("tx_data", tx_data, exp_d);
    idle(2);
    chk("tx_valid_hold", tx_valid, 1'b1);
    if (inject) send_byte(8'h33);
    tx_busy = 1'b1;
    @(posedge clk); #1;
    tx_busy = 1'b0;
    chk("tx_valid_drop", tx_valid, 1'b0);
    rd_pending = 1'b0;
    idle(1);
    chk("tx_valid_idle", tx_valid, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_addr"}, rf_addr, 4'h0);
    chk({tag, "_wdata"}, rf_wr_data, 8'h00);
    chk({tag, "_wr_en"}, rf_wr_en, 1'b0);
    chk({tag, "_rd_en"}, rf_rd_en, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    rf_rd_data = 8'h00; rf_rd_valid = 1'b0; tx_busy = 1'b0;
    rd_pending = 1'b0; last_rd_addr = 4'h0;
    for (int i = 0; i < 16; i++) rf_model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Basic write then read-back
    send_byte(8'hAA); idle(1); send_byte(8'h05); idle(1); send_byte(8'h3C);
    chk("wr_no_tx", tx_valid, 1'b0);
    idle(2);
    chk("addr_hold", rf_addr, 4'h5);
    chk("data_hold", rf_wr_data, 8'h3C);
    send_byte(8'hBB); idle(1); send_byte(8'h05);
    complete_read(1, 1'b0, 1'b0);

    // Garbage in IDLE, overrun during a read
    send_byte(8'h11); idle(1);
    send_byte(8'hBB); send_byte(8'h05);
    complete_read(2, 1'b1, 1'b0);

    // Back-to-back writes, opcode byte used as data
    send_byte(8'hAA); idle(1); send_byte(8'h01); idle(1); send_byte(8'h10); idle(1);
    send_byte(8'hAA); idle(1); send_byte(8'h02); idle(1); send_byte(8'h20); idle(1);
    send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hBB); idle(1);

    // Stray read-valid outside RD_WAIT
    rf_rd_data = 8'h77; rf_rd_valid = 1'b1;
    @(posedge clk); #1; rf_rd_valid = 1'b0;
    idle(2);
    chk("stray_rd_valid", tx_valid, 1'b0);

    // Busy already high when read data arrives
    send_byte(8'hBB); send_byte(8'h0A);
    complete_read(1, 1'b0, 1'b1);

    // Reset mid-frame
    send_byte(8'hAA); idle(1); send_byte(8'h07);
    rst = 1'b1; #1;
    check_zero_outputs("mid_rst");
    frame.delete(); rd_pending = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    send_byte(8'h99); idle(1);
    send_byte(8'hAA); send_byte(8'h0C); send_byte(8'hC5); idle(1);

`ifdef CTRL_TIMEOUT_EN
    begin
      int n = 0;
      send_byte(8'hAA);
      while (!frame_err && n < 40) begin
        @(posedge clk); #1; n++;
      end
      chk("timeout_pulse", frame_err, 1'b1);
      chk("timeout_wr_en", rf_wr_en, 1'b0);
      @(posedge clk); #1;
      chk("timeout_pulse_end", frame_err, 1'b0);
      frame.delete();
      send_byte(8'hAA); send_byte(8'h03); send_byte(8'h55); idle(1);
    end
`endif

    // Randomized frames: writes, reads and garbage bytes
    for (int k = 0; k < 30; k++) begin
      int kind = int'($urandom_range(2, 0));
      logic [7:0] b;
      if (kind == 0) begin
        send_byte(8'hAA); idle(int'($urandom_range(2, 0)));
        send_byte(8'($urandom)); idle(int'($urandom_range(2, 0)));
        send_byte(8'($urandom));
      end else if (kind == 1) begin
        send_byte(8'hBB); idle(int'($urandom_range(2, 0)));
        send_byte(8'($urandom));
        complete_read(int'($urandom_range(4, 1)), 1'($urandom), 1'($urandom));
      end else begin
        b = 8'($urandom);
        if (b == 8'hAA || b == 8'hBB) b = 8'h5A;
        send_byte(b);
      end
      idle(int'($urandom_range(2, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
